// File: rtl/data_register_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_register_access_ctrl
// Description : Byte-stream command front-end for the data register file.
//               Parses burst write / burst read packets, drives the register
//               file write port and read address, and streams read bytes out.
// Revision    : 1.0 - initial release
// ============================================================================

module data_register_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,

    output logic                  enable_write,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,

    output logic                  busy
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ADDR   = 3'd1;
    localparam logic [2:0] c_ST_WDATA  = 3'd2;
    localparam logic [2:0] c_ST_RD     = 3'd3;
    localparam logic [2:0] c_ST_RDRAIN = 3'd4;

    localparam int c_CNT_W = DATA_WIDTH - 1;

    logic [2:0]            r_state;
    logic                  r_op;
    logic [c_CNT_W-1:0]    r_count;
    logic [ADDR_WIDTH-1:0] r_addr_ptr;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic [2:0]            w_state_nxt;
    logic                  w_op_nxt;
    logic [c_CNT_W-1:0]    w_count_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_in_ready_nxt;
    logic                  w_accept;
    logic                  w_out_xfer;
    logic                  w_rd_load;
    logic                  w_wr_strobe;

    assign w_accept    = in_valid && r_in_ready;
    assign w_out_xfer  = r_out_valid && out_ready;
    // A new read byte may be loaded whenever the output slot is empty or draining.
    assign w_rd_load   = (r_state == c_ST_RD) && (!r_out_valid || out_ready);
    assign w_wr_strobe = (r_state == c_ST_WDATA) && w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_count_nxt = r_count;
        w_addr_nxt  = r_addr_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_op_nxt    = in_data[DATA_WIDTH-1];
                    w_count_nxt = in_data[DATA_WIDTH-2:0];
                    w_state_nxt = c_ST_ADDR;
                end
            end
            c_ST_ADDR: begin
                if (w_accept) begin
                    w_addr_nxt  = in_data[ADDR_WIDTH-1:0];
                    w_state_nxt = r_op ? c_ST_WDATA : c_ST_RD;
                end
            end
            c_ST_WDATA: begin
                if (w_accept) begin
                    w_addr_nxt = r_addr_ptr + 1'b1;
                    if (r_count == '0) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_count_nxt = r_count - 1'b1;
                    end
                end
            end
            c_ST_RD: begin
                if (w_rd_load) begin
                    w_addr_nxt = r_addr_ptr + 1'b1;
                    if (r_count == '0) begin
                        w_state_nxt = c_ST_RDRAIN;
                    end else begin
                        w_count_nxt = r_count - 1'b1;
                    end
                end
            end
            c_ST_RDRAIN: begin
                if (w_out_xfer) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Registered ready keeps in_ready low while reset is held.
    assign w_in_ready_nxt = (w_state_nxt == c_ST_IDLE) ||
                            (w_state_nxt == c_ST_ADDR) ||
                            (w_state_nxt == c_ST_WDATA);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_op       <= 1'b0;
            r_count    <= '0;
            r_addr_ptr <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_count    <= w_count_nxt;
            r_addr_ptr <= w_addr_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_strobe;
            if (w_wr_strobe) begin
                r_wr_addr <= r_addr_ptr;
                r_wr_data <= in_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_rd_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= read_data;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign enable_write = r_wr_en;
    assign write_addr   = r_wr_addr;
    assign write_data   = r_wr_data;
    // The read port is asynchronous, so it simply follows the burst pointer.
    assign read_addr    = r_addr_ptr;
    assign busy         = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_data_register_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_register_access_ctrl
// Description : Self-checking bench for data_register_access_ctrl with a
//               256x8 register file model and a packet-level reference.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_data_register_access_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       enable_write;
    logic [7:0] write_addr;
    logic [7:0] write_data;
    logic [7:0] read_addr;
    logic [7:0] read_data;
    logic       busy;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic        mem_clr;
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  wbuf [$];
    int          total = 0;
    int          bad   = 0;

    data_register_access_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .enable_write (enable_write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (enable_write === 1'b1) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},     32'(in_ready),     0);
        chk({tag, "_out_valid"},    32'(out_valid),    0);
        chk({tag, "_out_data"},     32'(out_data),     0);
        chk({tag, "_enable_write"}, 32'(enable_write), 0);
        chk({tag, "_write_addr"},   32'(write_addr),   0);
        chk({tag, "_write_data"},   32'(write_data),   0);
        chk({tag, "_read_addr"},    32'(read_addr),    0);
        chk({tag, "_busy"},         32'(busy),         0);
    endtask

    // Checks every write strobe and output transfer against the expected queues.
    task automatic monitor();
        logic       hold = 1'b0;
        logic [7:0] held = 8'h00;
        logic [15:0] w;
        logic [7:0]  r;
        forever begin
            @(negedge clock);
            #1;
            if (reset_n !== 1'b1) begin
                hold = 1'b0;
            end else begin
                if (enable_write === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        chk("write_unexpected", 32'(enable_write), 0);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_addr", 32'(write_addr), 32'(w[15:8]));
                        chk("write_data", 32'(write_data), 32'(w[7:0]));
                    end
                end
                if (hold) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_data",  32'(out_data),  32'(held));
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (rd_q.size() == 0) begin
                        chk("read_unexpected", 32'(out_valid), 0);
                    end else begin
                        r = rd_q.pop_front();
                        chk("read_byte", 32'(out_data), 32'(r));
                    end
                end
                hold = (out_valid === 1'b1) && (out_ready !== 1'b1);
                held = out_data;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit need_ready);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        if (need_ready) chk("in_ready_stream", 32'(in_ready), 1);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n == 100) chk("accept_timeout", 32'(in_ready), 1);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Sends header, address and the bytes held in wbuf; the model is updated up front.
    task automatic write_pkt(input logic [7:0] a, input int gap, input bit rnd, input bit keep_valid);
        int         n = wbuf.size();
        logic [7:0] wa;
        for (int i = 0; i < n; i++) begin
            wa = a + 8'(i);
            wr_q.push_back({wa, wbuf[i]});
            ref_mem[wa] = wbuf[i];
        end
        send_byte({1'b1, 7'(n - 1)}, 1'b0);
        send_byte(a, 1'b1);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], 1'b1);
            if (i != n - 1) begin
                if (rnd) idle($urandom_range(0, gap));
                else     idle(gap);
            end
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // mode 0: out_ready always high, 1: pattern 1,0,0,1, 2: random.
    task automatic read_pkt(input logic [7:0] a, input int n, input int mode);
        logic [3:0] pat = 4'b1001;
        int         k   = 0;
        for (int i = 0; i < n; i++) rd_q.push_back(ref_mem[a + 8'(i)]);
        send_byte({1'b0, 7'(n - 1)}, 1'b0);
        send_byte(a, 1'b1);
        while ((rd_q.size() != 0 || out_valid === 1'b1) && k < 3000) begin
            if (rd_q.size() != 0) chk("in_ready_during_read", 32'(in_ready), 0);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[k % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            // Garbage on the input while it is not ready must be ignored.
            in_valid = (rd_q.size() != 0);
            in_data  = 8'($urandom);
            @(negedge clock);
            k++;
        end
        if (k == 3000) chk("read_timeout", 32'(rd_q.size()), 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("read_end_in_ready",  32'(in_ready),  1);
        chk("read_end_out_valid", 32'(out_valid), 0);
        chk("read_end_busy",      32'(busy),      0);
    endtask

    initial begin
        logic [7:0] a;
        int         n;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        mem_clr   = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        fork
            monitor();
        join_none
        #1 reset_n = 1'b0;
        #1 check_reset("reset");
        repeat (3) @(negedge clock);
        mem_clr = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_reset_in_ready", 32'(in_ready), 1);

        // Single write
        wbuf = '{8'hA5};
        write_pkt(8'h10, 0, 1'b0, 1'b0);
        idle(2);
        chk("single_write_busy", 32'(busy), 0);
        chk("single_write_drained", 32'(wr_q.size()), 0);

        // Burst write across the 0xFF -> 0x00 wrap, then read back with backpressure
        wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_pkt(8'hFE, 0, 1'b0, 1'b0);
        idle(2);
        read_pkt(8'hFE, 4, 1);

        // Input stalls between write data bytes
        wbuf = '{8'hAA, 8'hBB, 8'hCC};
        write_pkt(8'h30, 3, 1'b0, 1'b0);
        idle(2);
        read_pkt(8'h30, 3, 0);

        // Read immediately after write
        wbuf = '{8'h5A};
        write_pkt(8'h05, 0, 1'b0, 1'b1);
        read_pkt(8'h05, 1, 0);
        idle(2);

        // Reset after 2 of 4 write bytes
        wr_q.push_back({8'h40, 8'hA1});
        wr_q.push_back({8'h41, 8'hA2});
        ref_mem[8'h40] = 8'hA1;
        ref_mem[8'h41] = 8'hA2;
        send_byte(8'h83, 1'b0);
        send_byte(8'h40, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        in_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset("mid_reset");
        chk("mid_reset_writes_done", 32'(wr_q.size()), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        idle(2);
        wbuf = '{8'h77};
        write_pkt(8'h20, 0, 1'b0, 1'b0);
        idle(2);
        read_pkt(8'h20, 1, 0);
        read_pkt(8'h40, 4, 2);

        // Randomised packets
        repeat (24) begin
            a = 8'($urandom);
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) begin
                wbuf.delete();
                for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
                write_pkt(a, 2, 1'b1, 1'b0);
                idle($urandom_range(0, 2));
            end else begin
                read_pkt(a, n, 2);
            end
        end

        // Maximum burst length, wrapping through address 0
        read_pkt(8'hC0, 128, 0);

        idle(3);
        chk("final_write_queue", 32'(wr_q.size()), 0);
        chk("final_read_queue",  32'(rd_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
